ex_mem_sequencer: RTL
=====================

EX_MEM_SEQUENCER -- requirements
Module: ex_mem_sequencer

Interface
REQ-001 Parameter ADDR_BASE, default 32'd1024: byte offset subtracted from alu_result to form sram_addr.
REQ-002 Parameter TIMEOUT_CYC, default 16: maximum REQ-state cycles before abort; only used when EX_MEM_TIMEOUT_EN is defined.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 valid_in  input  1  a valid instruction occupies EX.
REQ-006 mem_R_en  input  1  EX instruction is a load.
REQ-007 mem_W_en  input  1  EX instruction is a store.
REQ-008 alu_result  input  32  effective address from the ALU.
REQ-009 val_rm  input  32  store data.
REQ-010 sram_ready  input  1  memory completes the current access.
REQ-011 sram_rdata  input  32  read data, valid when sram_ready=1.
REQ-012 sram_req  output  1  access request to memory.
REQ-013 sram_we  output  1  1 = write, 0 = read.
REQ-014 sram_addr  output  32  registered address.
REQ-015 sram_wdata  output  32  registered store data.
REQ-016 freeze  output  1  stall IF/ID/EX pipeline registers.
REQ-017 rdata  output  32  last completed read data.
REQ-018 rdata_valid  output  1  one-cycle pulse when rdata is updated.
REQ-019 timeout_err  output  1  sticky abort flag.

Function
REQ-020 The FSM SHALL have exactly three states: IDLE, REQ and DONE.
REQ-021 IDLE, with valid_in & (mem_R_en | mem_W_en): capture alu_result-ADDR_BASE (mod 2^32), val_rm and we=mem_W_en; freeze=1 combinationally in that cycle; next state REQ.
REQ-022 If mem_R_en and mem_W_en are both 1, the access SHALL be treated as a write.
REQ-023 REQ: sram_req=1; sram_addr, sram_we and sram_wdata held stable; freeze=1; advance to DONE on the first edge where sram_ready=1.
REQ-024 On the REQ->DONE edge of a read, rdata SHALL load sram_rdata.
REQ-025 DONE: freeze=0, sram_req=0, rdata_valid=1 if the access was a read; next state IDLE unconditionally, so the still-present instruction does not retrigger.
REQ-026 sram_ready SHALL be ignored in IDLE and DONE.
REQ-027 Latency: minimum 2 frozen cycles (IDLE trigger + 1 REQ cycle); each extra low-ready cycle adds one.
REQ-028 rdata SHALL hold its value between reads; writes leave it unchanged.
REQ-029 freeze SHALL be 0 whenever there is no memory access.

Reset
REQ-030 When rst=1 at an edge: state=IDLE; sram_req, sram_we, freeze, rdata_valid and timeout_err = 0; sram_addr, sram_wdata and rdata = 32'd0.
REQ-031 Reset SHALL abort any in-flight access; sram_req is 0 from the first post-reset cycle.

Configuration
REQ-032 With EX_MEM_TIMEOUT_EN defined:
- a counter increments in REQ and clears on entry to REQ;
- on reaching TIMEOUT_CYC with sram_ready=0, the FSM goes to DONE, sets timeout_err, and leaves rdata unchanged;
- rdata_valid stays 0 for the aborted access.
REQ-033 Without EX_MEM_TIMEOUT_EN: REQ waits indefinitely, no counter is built, and timeout_err is tied to 0; the port list is identical in both builds.

Structure
REQ-034 Package ex_mem_seq_pkg SHALL hold the state enum (IDLE/REQ/DONE), ADDR_BASE_DEF=32'd1024 and TIMEOUT_CYC_DEF=16.
REQ-035 The timeout counter SHALL be a sub-module, mem_timeout_counter, instantiated only under EX_MEM_TIMEOUT_EN.

Verification
REQ-036 Load, alu_result=32'h0000_0410, sram_ready high on 1st REQ cycle, rdata=32'hCAFE_0001 -> sram_addr=32'h10, freeze high 2 cycles, rdata_valid pulse once, rdata=32'hCAFE_0001.
REQ-037 Store, val_rm=32'h1234_5678, ready after 3 REQ cycles -> sram_we=1, sram_wdata stable all 3 cycles, freeze high 4 cycles, rdata unchanged.
REQ-038 mem_R_en=mem_W_en=1 -> write issued; alu_result=32'd0 -> sram_addr=32'hFFFF_FC00.
REQ-039 rst asserted during 2nd REQ cycle -> next cycle IDLE, sram_req=0, freeze=0, all outputs at reset values.
REQ-040 EX_MEM_TIMEOUT_EN, TIMEOUT_CYC=4, ready never asserted -> sram_req drops after 4 REQ cycles, timeout_err=1 until rst, rdata_valid stays 0; without the macro the FSM stays in REQ for 100 cycles.
REQ-041 Back-to-back loads on consecutive instructions -> the second request starts in the cycle after DONE, and each produces exactly one rdata_valid pulse.

Source files
------------

// File: rtl/ex_mem_seq_pkg.sv
// Shared types and defaults for the EX->MEM access sequencer.
package ex_mem_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ADDR_BASE_DEF   = 32'd1024;
    localparam int          TIMEOUT_CYC_DEF = 16;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts cycles spent waiting in REQ; expired marks the last cycle allowed before abort.
module mem_timeout_counter #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] count;

    // Saturates once expired so a stalled FSM cannot wrap the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == CW'(LIMIT - 1));

endmodule

// File: rtl/ex_mem_sequencer.sv
// Freezes IF/ID/EX around each SRAM load/store with a three-state handshake.
// Define EX_MEM_TIMEOUT_EN to build the REQ-state watchdog (mem_timeout_counter).
module ex_mem_sequencer
    import ex_mem_seq_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = ADDR_BASE_DEF,
    parameter int          TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    input  logic        mem_R_en,
    input  logic        mem_W_en,
    input  logic [31:0] alu_result,
    input  logic [31:0] val_rm,
    input  logic        sram_ready,
    input  logic [31:0] sram_rdata,
    output logic        sram_req,
    output logic        sram_we,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    output logic        freeze,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        timeout_err
);

    state_t state;
    state_t next_state;
    logic   start;
    logic   in_req;
    logic   we_q;
    logic   timeout_hit;
    logic   aborted;

    assign start  = (state == IDLE) && valid_in && (mem_R_en || mem_W_en);
    assign in_req = (state == REQ);

    // freeze is raised combinationally in the trigger cycle so the
    // instruction stays put while its operands are being captured.
    always_comb begin
        next_state  = state;
        freeze      = 1'b0;
        sram_req    = 1'b0;
        rdata_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    freeze     = 1'b1;
                    next_state = REQ;
                end
            end
            REQ: begin
                freeze   = 1'b1;
                sram_req = 1'b1;
                if (sram_ready || timeout_hit) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                rdata_valid = ~we_q & ~aborted;
                next_state  = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    // Simultaneous load+store enables resolve to a write via mem_W_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sram_addr  <= '0;
            sram_wdata <= '0;
            we_q       <= 1'b0;
            rdata      <= '0;
        end else begin
            state <= next_state;
            if (start) begin
                sram_addr  <= alu_result - ADDR_BASE;
                sram_wdata <= val_rm;
                we_q       <= mem_W_en;
            end
            if (in_req && sram_ready && !we_q) begin
                rdata <= sram_rdata;
            end
        end
    end

    assign sram_we = we_q;

`ifdef EX_MEM_TIMEOUT_EN
    logic err_q;
    logic aborted_q;

    mem_timeout_counter #(
        .LIMIT(TIMEOUT_CYC)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (start),
        .enable (in_req),
        .expired(timeout_hit)
    );

    // aborted_q suppresses the read pulse of a timed-out access only.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q     <= 1'b0;
            aborted_q <= 1'b0;
        end else if (start) begin
            aborted_q <= 1'b0;
        end else if (in_req && !sram_ready && timeout_hit) begin
            aborted_q <= 1'b1;
            err_q     <= 1'b1;
        end
    end

    assign aborted     = aborted_q;
    assign timeout_err = err_q;
`else
    assign timeout_hit = 1'b0;
    assign aborted     = 1'b0;
    assign timeout_err = 1'b0;
`endif

endmodule
